// File: rtl/udlx_regfile_pkg.sv
// udlx_regfile_pkg: shared defaults, register-zero index and busy-vector popcount
package udlx_regfile_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_MEMORY_SIZE = 32;
  localparam int DEFAULT_ADDRESS_WIDTH = 5;
  localparam int MAX_REGS = 64;
  localparam int REG_ZERO = 0;
  function automatic int popcount(input logic [MAX_REGS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_REGS; i++) n = n + 32'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bits, reservation handshake, pending count and sticky write error (REGFILE_BYPASS_EN masks read_busy on a same-cycle write)
module regfile_scoreboard import udlx_regfile_pkg::*; #(
  parameter int MEMORY_SIZE = DEFAULT_MEMORY_SIZE,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_READ_PORTS*ADDRESS_WIDTH-1:0] read_address,
  output logic [NUM_READ_PORTS-1:0]              read_busy,
  input  logic                                   reserve_enable,
  input  logic [ADDRESS_WIDTH-1:0]               reserve_address,
  output logic                                   reserve_ready,
  input  logic                                   write_enable,
  input  logic [ADDRESS_WIDTH-1:0]               write_address,
  output logic [ADDRESS_WIDTH:0]                 pending_count,
  output logic                                   write_error
);
  logic [MEMORY_SIZE-1:0] busy, busy_nxt;
  logic [ADDRESS_WIDTH-1:0] a;
  function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] x);
    return 32'(x) < MEMORY_SIZE;
  endfunction
  function automatic logic busy_at(input logic [ADDRESS_WIDTH-1:0] x);
    return in_range(x) ? busy[x] : 1'b0;
  endfunction
  always_comb begin
    a = '0;
    reserve_ready = ~busy_at(reserve_address) | (write_enable & write_address == reserve_address);
    // release applies before the new reservation, so a same-cycle write+reserve leaves the register owned
    for (int r = 0; r < MEMORY_SIZE; r++)
      busy_nxt[r] = (busy[r] & ~(write_enable & write_address == ADDRESS_WIDTH'(r))) |
                    (reserve_enable & reserve_ready & reserve_address == ADDRESS_WIDTH'(r) & r != REG_ZERO);
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      a = read_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
`ifdef REGFILE_BYPASS_EN
      read_busy[i] = busy_at(a) & ~(write_enable & write_address == a & a != ADDRESS_WIDTH'(REG_ZERO));
`else
      read_busy[i] = busy_at(a);
`endif
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      busy <= '0;
      pending_count <= '0;
      write_error <= 1'b0;
    end else begin
      busy <= busy_nxt;
      pending_count <= (ADDRESS_WIDTH+1)'(popcount(MAX_REGS'(busy_nxt)));
      write_error <= write_error | (write_enable & write_address != ADDRESS_WIDTH'(REG_ZERO) &
                                    in_range(write_address) & ~busy_at(write_address));
    end
endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: multi-port register bank with hardwired r0 and hazard scoreboard; REGFILE_BYPASS_EN forwards write data to same-cycle reads
module register_file_sb import udlx_regfile_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MEMORY_SIZE = DEFAULT_MEMORY_SIZE,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_READ_PORTS*ADDRESS_WIDTH-1:0] read_address,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]    read_data,
  output logic [NUM_READ_PORTS-1:0]              read_busy,
  input  logic                                   reserve_enable,
  input  logic [ADDRESS_WIDTH-1:0]               reserve_address,
  output logic                                   reserve_ready,
  input  logic                                   write_enable,
  input  logic [ADDRESS_WIDTH-1:0]               write_address,
  input  logic [DATA_WIDTH-1:0]                  write_data,
  output logic [ADDRESS_WIDTH:0]                 pending_count,
  output logic                                   write_error
);
  logic [DATA_WIDTH-1:0] mem [MEMORY_SIZE];
  logic [ADDRESS_WIDTH-1:0] a;
  function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] x);
    return 32'(x) < MEMORY_SIZE;
  endfunction
  always_ff @(posedge clk)
    if (rst) for (int r = 0; r < MEMORY_SIZE; r++) mem[r] <= '0;
    else if (write_enable && write_address != ADDRESS_WIDTH'(REG_ZERO) && in_range(write_address))
      mem[write_address] <= write_data;
  always_comb begin
    a = '0;
    read_data = '0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      a = read_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      read_data[i*DATA_WIDTH +: DATA_WIDTH] = (a == ADDRESS_WIDTH'(REG_ZERO) || !in_range(a)) ? '0 : mem[a];
`ifdef REGFILE_BYPASS_EN
      if (write_enable && write_address == a && a != ADDRESS_WIDTH'(REG_ZERO) && in_range(a))
        read_data[i*DATA_WIDTH +: DATA_WIDTH] = write_data;
`endif
    end
  end
  regfile_scoreboard #(
    .MEMORY_SIZE(MEMORY_SIZE),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .NUM_READ_PORTS(NUM_READ_PORTS)
  ) u_sb (
    .clk(clk),
    .rst(rst),
    .read_address(read_address),
    .read_busy(read_busy),
    .reserve_enable(reserve_enable),
    .reserve_address(reserve_address),
    .reserve_ready(reserve_ready),
    .write_enable(write_enable),
    .write_address(write_address),
    .pending_count(pending_count),
    .write_error(write_error)
  );
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed stimulus with queued expectations checked by a negedge monitor
module tb_register_file_sb;
  localparam int DW = 32, AW = 5, NP = 3;
  localparam int K_DATA = 0, K_BUSY = 1, K_PEND = 2, K_WERR = 3, K_RDY = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP*AW-1:0] read_address = '0;
  logic [NP*DW-1:0] read_data;
  logic [NP-1:0] read_busy;
  logic reserve_enable = 1'b0;
  logic [AW-1:0] reserve_address = '0;
  logic reserve_ready;
  logic write_enable = 1'b0;
  logic [AW-1:0] write_address = '0;
  logic [DW-1:0] write_data = '0;
  logic [AW:0] pending_count;
  logic write_error;
  typedef struct {
    string name;
    int kind;
    int port;
    logic [31:0] exp;
  } chk_t;
  chk_t q[$];
  int errors = 0;
  int checks = 0;
  register_file_sb #(.DATA_WIDTH(DW), .MEMORY_SIZE(32), .ADDRESS_WIDTH(AW), .NUM_READ_PORTS(NP)) dut (
    .clk(clk),
    .rst(rst),
    .read_address(read_address),
    .read_data(read_data),
    .read_busy(read_busy),
    .reserve_enable(reserve_enable),
    .reserve_address(reserve_address),
    .reserve_ready(reserve_ready),
    .write_enable(write_enable),
    .write_address(write_address),
    .write_data(write_data),
    .pending_count(pending_count),
    .write_error(write_error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = q.pop_front();
      case (c.kind)
        K_DATA: act = read_data[c.port*DW +: DW];
        K_BUSY: act = 32'(read_busy[c.port]);
        K_PEND: act = 32'(pending_count);
        K_WERR: act = 32'(write_error);
        default: act = 32'(reserve_ready);
      endcase
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s port%0d: got %h expected %h", c.name, c.port, act, c.exp);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    reserve_enable = 1'b0;
    write_enable = 1'b0;
  endtask
  task automatic rd(input int a0, input int a1, input int a2);
    read_address = {AW'(a2), AW'(a1), AW'(a0)};
  endtask
  task automatic rsv(input int a);
    reserve_enable = 1'b1;
    reserve_address = AW'(a);
  endtask
  task automatic wr(input int a, input logic [31:0] d);
    write_enable = 1'b1;
    write_address = AW'(a);
    write_data = d;
  endtask
  task automatic want(input string n, input int k, input int p, input logic [31:0] v);
    q.push_back('{n, k, p, v});
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      step();
      rd(a, a, a);
      for (int p = 0; p < NP; p++) begin
        want("reset_data", K_DATA, p, 0);
        want("reset_busy", K_BUSY, p, 0);
      end
      want("reset_pending", K_PEND, 0, 0);
      want("reset_werr", K_WERR, 0, 0);
    end
    step(); rsv(5); want("r5_ready", K_RDY, 0, 1);
    step(); rd(5, 0, 0); want("r5_busy", K_BUSY, 0, 1); want("r5_pending", K_PEND, 0, 1);
    step(); wr(5, 32'hDEADBEEF);
    want("r5_bypass_data", K_DATA, 0, BYP ? 32'hDEADBEEF : 32'h0);
    want("r5_bypass_busy", K_BUSY, 0, BYP ? 0 : 1);
    step(); want("r5_after_data", K_DATA, 0, 32'hDEADBEEF); want("r5_after_busy", K_BUSY, 0, 0);
    want("r5_after_pending", K_PEND, 0, 0); want("r5_werr", K_WERR, 0, 0);
    step(); rsv(7); rd(7, 0, 0); want("r7_ready_first", K_RDY, 0, 1);
    step(); rsv(7); want("r7_waw_stall", K_RDY, 0, 0); want("r7_pending", K_PEND, 0, 1);
    step(); want("r7_busy_held", K_BUSY, 0, 1); want("r7_pending_held", K_PEND, 0, 1);
    step(); wr(7, 32'h77); rsv(7); want("r7_wr_rsv_ready", K_RDY, 0, 1);
    step(); want("r7_new_owner_busy", K_BUSY, 0, 1); want("r7_new_owner_pending", K_PEND, 0, 1);
    want("r7_data", K_DATA, 0, 32'h77); want("r7_werr", K_WERR, 0, 0);
    step(); wr(7, 32'h70);
    step(); want("r7_released", K_PEND, 0, 0); want("r7_release_data", K_DATA, 0, 32'h70);
    step(); rd(0, 0, 0); wr(0, 32'h12345678); rsv(0);
    want("r0_ready", K_RDY, 0, 1); want("r0_wr_data", K_DATA, 0, 0); want("r0_wr_busy", K_BUSY, 0, 0);
    step(); want("r0_data", K_DATA, 0, 0); want("r0_busy", K_BUSY, 0, 0);
    want("r0_werr", K_WERR, 0, 0); want("r0_pending", K_PEND, 0, 0);
    step(); wr(9, 32'h99);
    step(); rd(9, 0, 0); want("r9_werr", K_WERR, 0, 1); want("r9_data", K_DATA, 0, 32'h99);
    step(); rsv(3);
    step(); rsv(4); want("r4_ready", K_RDY, 0, 1);
    step(); wr(4, 32'h44);
    step(); rd(3, 3, 4); wr(3, 32'hA5);
    want("p0_r3_data", K_DATA, 0, BYP ? 32'hA5 : 32'h0);
    want("p1_r3_data", K_DATA, 1, BYP ? 32'hA5 : 32'h0);
    want("p2_r4_data", K_DATA, 2, 32'h44);
    want("p0_r3_busy", K_BUSY, 0, BYP ? 0 : 1);
    want("p1_r3_busy", K_BUSY, 1, BYP ? 0 : 1);
    want("p2_r4_busy", K_BUSY, 2, 0);
    want("r3_pending", K_PEND, 0, 1);
    want("werr_sticky", K_WERR, 0, 1);
    step(); want("r3_after_data", K_DATA, 0, 32'hA5); want("r3_after_pending", K_PEND, 0, 0);
    want("werr_sticky2", K_WERR, 0, 1);
    step(); rsv(10);
    step(); rst = 1'b1; rsv(11); wr(12, 32'hCC);
    step(); rst = 1'b0; rd(5, 11, 10);
    for (int p = 0; p < NP; p++) begin
      want("post_rst_data", K_DATA, p, 0);
      want("post_rst_busy", K_BUSY, p, 0);
    end
    want("post_rst_pending", K_PEND, 0, 0); want("post_rst_werr", K_WERR, 0, 0);
    step(); rd(12, 3, 9);
    for (int p = 0; p < NP; p++) want("post_rst_data2", K_DATA, p, 0);
    step();
    step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
